// File: rtl/freq_decision_if.sv
// Blink-input / decision-output bundle for freq_decision.
// The slave side is the classifier; the master side feeds blinky and watches the answer.
interface freq_decision_if #(
    parameter int ANS_W = 3
);
    logic             blinky;
    logic [ANS_W-1:0] finalAnswer;
    logic             finalDone;
    logic             answerChanged;

    modport master (
        output blinky,
        input  finalAnswer,
        input  finalDone,
        input  answerChanged
    );

    modport slave (
        input  blinky,
        output finalAnswer,
        output finalDone,
        output answerChanged
    );
endinterface

// File: rtl/freq_decision.sv
// Measures the rising-edge period of the asynchronous blinky input and declares one of
// NUM_CLASSES target periods after CONFIRM consecutive in-tolerance periods.
module freq_decision #(
    parameter int                              NUM_CLASSES = 4,
    parameter int                              PERIOD_W    = 20,
    parameter logic [NUM_CLASSES*PERIOD_W-1:0] TARGETS     = {20'd500_000, 20'd200_000,
                                                              20'd100_000, 20'd50_000},
    parameter int                              TOL_SHIFT   = 3,
    parameter int                              CONFIRM     = 4,
    parameter int                              TIMEOUT     = 2**PERIOD_W-1,
    parameter bit                              ONE_SHOT    = 1'b1,
    localparam int                             ANS_W       = $clog2(NUM_CLASSES+1),
    localparam int                             STREAK_W    = $clog2(CONFIRM+1)
) (
    input  logic            clk,
    input  logic            rst,
    freq_decision_if.slave  bus
);

    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    logic                sync3_q, sync3_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                have_prev_q, have_prev_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [ANS_W-1:0]    cand_q, cand_d;
    logic [ANS_W-1:0]    final_answer_q, final_answer_d;
    logic                final_done_q, final_done_d;
    logic                answer_changed_q, answer_changed_d;

    logic                edge_det;
    logic                timeout;
    logic                frozen;
    logic [ANS_W-1:0]    match_cls;

    // |p - t| <= t >> TOL_SHIFT, computed one bit wider so the difference never wraps.
    function automatic logic in_window(input logic [PERIOD_W-1:0] p,
                                       input logic [PERIOD_W-1:0] t);
        logic [PERIOD_W:0] diff;
        diff = (p >= t) ? ({1'b0, p} - {1'b0, t}) : ({1'b0, t} - {1'b0, p});
        return diff <= ({1'b0, t} >> TOL_SHIFT);
    endfunction

    // Class encoded as index+1 so zero means "no match"; descending loop lets the lowest index win.
    always_comb begin
        match_cls = '0;
        for (int i = NUM_CLASSES - 1; i >= 0; i--) begin
            if (in_window(cnt_q, TARGETS[i*PERIOD_W +: PERIOD_W])) begin
                match_cls = ANS_W'(i + 1);
            end
        end
    end

    always_comb begin
        edge_det         = sync2_q & ~sync3_q;
        timeout          = (cnt_q == PERIOD_W'(TIMEOUT)) && !edge_det;
        frozen           = ONE_SHOT && final_done_q;

        sync1_d          = bus.blinky;
        sync2_d          = sync1_q;
        sync3_d          = sync2_q;
        cnt_d            = cnt_q;
        have_prev_d      = have_prev_q;
        streak_d         = streak_q;
        cand_d           = cand_q;
        final_answer_d   = final_answer_q;
        final_done_d     = final_done_q;
        answer_changed_d = 1'b0;

        if (edge_det) begin
            cnt_d = PERIOD_W'(1);
        end else if (cnt_q != PERIOD_W'(TIMEOUT)) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (edge_det) begin
            have_prev_d = 1'b1;
            if (have_prev_q && !frozen) begin
                if (match_cls == '0) begin
                    streak_d = '0;
                    cand_d   = '0;
                end else if (match_cls == cand_q) begin
                    if (streak_q != STREAK_W'(CONFIRM)) streak_d = streak_q + 1'b1;
                end else begin
                    cand_d   = match_cls;
                    streak_d = STREAK_W'(1);
                end
            end
        end else if (timeout) begin
            have_prev_d = 1'b0;
            if (!frozen) begin
                streak_d = '0;
                cand_d   = '0;
            end
        end

        // Timeout clears a tracked answer once; after that final_answer_q is 0 so it cannot repeat.
        if (timeout && !ONE_SHOT) begin
            if (final_answer_q != '0) begin
                final_answer_d   = '0;
                final_done_d     = 1'b0;
                answer_changed_d = 1'b1;
            end
        end else if (!frozen && streak_q == STREAK_W'(CONFIRM) && cand_q != final_answer_q) begin
            final_answer_d   = cand_q;
            final_done_d     = 1'b1;
            answer_changed_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q          <= 1'b0;
            sync2_q          <= 1'b0;
            sync3_q          <= 1'b0;
            cnt_q            <= '0;
            have_prev_q      <= 1'b0;
            streak_q         <= '0;
            cand_q           <= '0;
            final_answer_q   <= '0;
            final_done_q     <= 1'b0;
            answer_changed_q <= 1'b0;
        end else begin
            sync1_q          <= sync1_d;
            sync2_q          <= sync2_d;
            sync3_q          <= sync3_d;
            cnt_q            <= cnt_d;
            have_prev_q      <= have_prev_d;
            streak_q         <= streak_d;
            cand_q           <= cand_d;
            final_answer_q   <= final_answer_d;
            final_done_q     <= final_done_d;
            answer_changed_q <= answer_changed_d;
        end
    end

    assign bus.finalAnswer   = final_answer_q;
    assign bus.finalDone     = final_done_q;
    assign bus.answerChanged = answer_changed_q;

endmodule
